// File: rtl/dump_seq_ctrl.sv
// dump_seq_ctrl
// Plays a small table of DUMP entries (dump_choice/dump_para), one entry per
// bridge cycle: load DUMP, arm on a fresh bri_cycle rising edge, fire
// state_start/pluse_start, then track DUMP's dump_on pulse before moving on.
//
// Handshake summary: seq_go is accepted only while idle (seq_busy=0) and is a
// single-cycle request with no ready return; seq_busy rises the cycle after an
// accepted go and falls in the first idle cycle. Toward DUMP, dump_load and
// state_start/pluse_start are one-cycle pulses with no back-pressure; dump_on
// going 1 then 0 is taken as completion of the fired entry. seq_abort forces
// idle from any active state and outranks every other request.
module dump_seq_ctrl #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int PARA_W  = 12,
    parameter int TMO_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [2:0]        cfg_choice,
    input  logic [PARA_W-1:0] cfg_para,
    input  logic [AW:0]       seq_len,
    input  logic              seq_go,
    input  logic              seq_abort,
    input  logic              bri_cycle,
    input  logic              dump_on,
    output logic [2:0]        dump_choice,
    output logic [PARA_W-1:0] dump_para,
    output logic              dump_load,
    output logic              state_start,
    output logic              pluse_start,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [AW-1:0]     seq_idx,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_ARM      = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_WAIT_ACT = 3'd4;
    localparam logic [2:0] S_WAIT_END = 3'd5;
    localparam logic [2:0] S_NEXT     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [AW:0]      DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic [TMO_W-1:0]  tmo_q;
    logic              bri_prev_q;
    logic              err_q;
    logic [2:0]        choice_q;
    logic [PARA_W-1:0] para_q;

    logic [2:0]        tbl_choice_q [DEPTH];
    logic [PARA_W-1:0] tbl_para_q   [DEPTH];

    logic              go_acc;
    logic              we_acc;
    logic              bri_rise;
    logic              in_tmo;
    logic              tmo_hit;
    logic              last_entry;
    logic [AW:0]       len_clamp;
    logic              load_en;
    logic [AW-1:0]     load_idx;
    logic [2:0]        ld_choice;
    logic [PARA_W-1:0] ld_para;

    assign go_acc     = (state_q == S_IDLE) && seq_go && !seq_abort;
    assign we_acc     = (state_q == S_IDLE) && cfg_we;
    assign bri_rise   = bri_cycle && !bri_prev_q;
    assign in_tmo     = (state_q == S_ARM) || (state_q == S_WAIT_ACT) ||
                        (state_q == S_WAIT_END);
    assign tmo_hit    = in_tmo && (tmo_q == TMO_LAST);
    assign last_entry = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    assign len_clamp  = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;

    // Next-state logic: abort beats timeout, timeout beats normal progress.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        load_en  = 1'b0;
        load_idx = idx_q;
        case (state_q)
            S_IDLE: begin
                if (go_acc) begin
                    len_d = len_clamp;
                    idx_d = '0;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_LOAD;
                        load_en  = 1'b1;
                        load_idx = '0;
                    end
                end
            end
            S_LOAD:     state_d = S_ARM;
            S_ARM:      if (bri_rise) state_d = S_START;
            S_START:    state_d = S_WAIT_ACT;
            S_WAIT_ACT: if (dump_on) state_d = S_WAIT_END;
            S_WAIT_END: if (!dump_on) state_d = S_NEXT;
            S_NEXT: begin
                if (last_entry) begin
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + AW'(1);
                    state_d  = S_LOAD;
                    load_en  = 1'b1;
                    load_idx = idx_q + AW'(1);
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = S_IDLE;
            load_en = 1'b0;
        end
        if (seq_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            load_en = 1'b0;
        end
    end

    // Entry fetch: a write landing on the same cycle as go is forwarded so the
    // first load sees the new value.
    always_comb begin
        ld_choice = tbl_choice_q[load_idx];
        ld_para   = tbl_para_q[load_idx];
        if (we_acc && (cfg_addr == load_idx)) begin
            ld_choice = cfg_choice;
            ld_para   = cfg_para;
        end
    end

    // Control registers: state, entry index, latched length, bri_cycle history.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            bri_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            bri_prev_q <= bri_cycle;
        end
    end

    // Per-entry watchdog: restarts in LOAD, counts while waiting on bri/DUMP.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_q == S_LOAD) begin
            tmo_q <= '0;
        end else if (in_tmo) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // Sticky timeout flag, cleared by the next accepted go.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (go_acc) begin
            err_q <= 1'b0;
        end else if (tmo_hit && !seq_abort) begin
            err_q <= 1'b1;
        end
    end

    // DUMP parameter registers: updated only when entering LOAD, held otherwise.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            choice_q <= '0;
            para_q   <= '0;
        end else if (load_en) begin
            choice_q <= ld_choice;
            para_q   <= ld_para;
        end
    end

    // Entry table: writable only while idle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_choice_q[i] <= '0;
                tbl_para_q[i]   <= '0;
            end
        end else if (we_acc) begin
            tbl_choice_q[cfg_addr] <= cfg_choice;
            tbl_para_q[cfg_addr]   <= cfg_para;
        end
    end

    assign dump_choice = choice_q;
    assign dump_para   = para_q;
    assign dump_load   = (state_q == S_LOAD);
    assign state_start = (state_q == S_START);
    assign pluse_start = (state_q == S_START);
    assign seq_busy    = (state_q != S_IDLE);
    assign seq_done    = (state_q == S_DONE);
    assign seq_err     = err_q;
    assign seq_idx     = idx_q;
    assign dbg_state   = state_q;

endmodule
